// File: rtl/bcd_seg_pkg.sv
// Shared constants and types for the packed-BCD 7-segment scanner.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package bcd_seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Nibbles A..F show a dash.
module bcd_to_seg
    import bcd_seg_pkg::*;
(
    input  logic [3:0]       bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with BCD shadow register.
// Define BCD_SEG_LZB_EN to enable leading-zero blanking.
module bcd_seg_scanner
    import bcd_seg_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    input  logic                  LOAD,
    output logic [SEG_W-1:0]      SEG,
    output logic [DIGITS-1:0]     DIG,
    output logic                  SLOT_END
);

    localparam int KW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [KW-1:0]       k_q, k_d;
    logic [IW-1:0]       idx_q, idx_d;
    state_e              state_q, state_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                end_q, end_d;

    logic                last_k;
    logic [3:0]          nib;
    logic [SEG_W-1:0]    dec_seg;
    logic                blank_lz;

    bcd_to_seg u_dec (
        .bcd_i (nib),
        .seg_o (dec_seg)
    );

    // k_q/idx_q hold the slot position of the cycle that begins at the next edge
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) nib = shadow_q[4*i +: 4];
        end
    end

`ifdef BCD_SEG_LZB_EN
    always_comb begin
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) >= idx_q && shadow_q[4*j +: 4] != 4'h0) nz = 1'b1;
        end
        blank_lz = (idx_q != '0) && !nz;
    end
`else
    assign blank_lz = 1'b0;
`endif

    always_comb begin
        shadow_d = LOAD ? BCD_IN : shadow_q;
        last_k   = (k_q == KW'(SCAN_DIV - 1));
        k_d      = last_k ? '0 : k_q + KW'(1);
        idx_d    = idx_q;
        if (last_k) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (k_q == KW'(BLANK_CYC)) state_d = ST_SHOW;
            ST_SHOW:  if (k_q == '0)             state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        seg_d = SEG_OFF;
        dig_d = '1;
        end_d = last_k;
        if (state_d == ST_SHOW) begin
            dig_d = ~(DIGITS'(1) << idx_q);
            seg_d = blank_lz ? SEG_OFF : dec_seg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_q <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            state_q  <= ST_BLANK;
            seg_q    <= SEG_OFF;
            dig_q    <= '1;
            end_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            end_q    <= end_d;
        end
    end

    assign SEG      = seg_q;
    assign DIG      = dig_q;
    assign SLOT_END = end_q;

endmodule
